// File: rtl/cla_pkg.sv
// cla_pkg -- shared definitions for the pipelined carry-lookahead adder.
//   cla_op_e  : operation encoding (OP_ADD = 0, OP_SUB = 1)
//   cla_width : datapath width helper, returns n**levels
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } cla_op_e;

  // Integer power used to size the datapath from group size and level count.
  function automatic int cla_width(input int n, input int levels);
    int w;
    w = 1;
    for (int i = 0; i < levels; i++) begin
      w = w * n;
    end
    return w;
  endfunction

endpackage

// File: rtl/cla_group_stage.sv
// cla_group_stage -- one lookahead group of N children at one level.
// Ports:
//   g, p   in  N  child generate / propagate
//   gg, gp out 1  group generate / propagate
//   pg, pp out N  prefix generate / propagate into each child, measured from
//                 the group's own carry-in (pg[0] = 0, pp[0] = 1). A child's
//                 carry-in is pg[i] | (pp[i] & group_carry_in).
module cla_group_stage #(
  parameter int N = 4
) (
  input  logic [N-1:0] g,
  input  logic [N-1:0] p,
  output logic         gg,
  output logic         gp,
  output logic [N-1:0] pg,
  output logic [N-1:0] pp
);

  // Prefix generate/propagate across the children; the loop unrolls into
  // flat lookahead terms.
  always_comb begin
    logic gen_acc;
    logic prop_acc;
    gen_acc  = 1'b0;
    prop_acc = 1'b1;
    pg       = '0;
    pp       = '0;
    for (int i = 0; i < N; i++) begin
      pg[i]    = gen_acc;
      pp[i]    = prop_acc;
      gen_acc  = g[i] | (p[i] & gen_acc);
      prop_acc = p[i] & prop_acc;
    end
    gg = gen_acc;
    gp = prop_acc;
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder -- W = N**LEVELS bit add/subtract, LEVELS+1 stages,
// valid/ready handshake on both sides.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand handshake (in_ready = out_ready | !out_valid)
//   a, b, c_in, op       operands, carry-in (add only), 0 = add, 1 = a - b
//   out_valid / out_ready result handshake
//   sum, c_out, overflow result, carry-out (sub: 1 = no borrow), signed ovf
// Build option: define PIPELINED_CLA_OVERFLOW_EN to compute overflow;
// otherwise the overflow port is tied to 0.
//
// Each intermediate stage keeps, per bit, a (generate, propagate) prefix from
// the start of the enclosing lookahead group at the current level. Resolving
// one level folds the parent-group prefix of each child into those bit
// prefixes, so after the top level they are absolute prefixes and only the
// real carry-in remains to be applied.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int LEVELS = 2,
  localparam int W      = cla_width(N, LEVELS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int TOP = LEVELS - 1;

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int SPAN = cla_width(N, k);   // bits per level-k group
    localparam int MK   = W / SPAN;          // level-k groups
    localparam int MN   = MK / N;            // level-(k+1) groups

    logic          valid_r;
    logic          cin_r;
    logic [W-1:0]  pbit_r;                   // per-bit a ^ b_eff for the sum
    logic [W-1:0]  bg_r;
    logic [W-1:0]  bp_r;
    logic [MK-1:0] gg_r;
    logic [MK-1:0] gp_r;
    logic [MN-1:0] nxt_gg;
    logic [MN-1:0] nxt_gp;
    logic [MK-1:0] cg;
    logic [MK-1:0] cp;
    logic [W-1:0]  nxt_bg;
    logic [W-1:0]  nxt_bp;

    if (k == 0) begin : g_load
      logic [W-1:0] b_eff;
      logic         cin_eff;

      // Subtraction is a + ~b + 1; the external carry-in is ignored then.
      always_comb begin
        b_eff   = (op == OP_SUB) ? ~b : b;
        cin_eff = (op == OP_SUB) ? 1'b1 : c_in;
      end

      // Stage 1: capture per-bit generate/propagate; each bit starts as its own group.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_r <= 1'b0;
          cin_r   <= 1'b0;
          pbit_r  <= '0;
          bg_r    <= '0;
          bp_r    <= '0;
          gg_r    <= '0;
          gp_r    <= '0;
        end else if (advance) begin
          valid_r <= in_valid;
          cin_r   <= cin_eff;
          pbit_r  <= a ^ b_eff;
          bg_r    <= '0;
          bp_r    <= '1;
          gg_r    <= a & b_eff;
          gp_r    <= a ^ b_eff;
        end
      end
    end else begin : g_load
      // Later stages: register the previous level's resolved prefixes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_r <= 1'b0;
          cin_r   <= 1'b0;
          pbit_r  <= '0;
          bg_r    <= '0;
          bp_r    <= '0;
          gg_r    <= '0;
          gp_r    <= '0;
        end else if (advance) begin
          valid_r <= g_lvl[k-1].valid_r;
          cin_r   <= g_lvl[k-1].cin_r;
          pbit_r  <= g_lvl[k-1].pbit_r;
          bg_r    <= g_lvl[k-1].nxt_bg;
          bp_r    <= g_lvl[k-1].nxt_bp;
          gg_r    <= g_lvl[k-1].nxt_gg;
          gp_r    <= g_lvl[k-1].nxt_gp;
        end
      end
    end

    for (genvar j = 0; j < MN; j++) begin : g_grp
      cla_group_stage #(.N(N)) u_grp (
        .g  (gg_r[j*N +: N]),
        .p  (gp_r[j*N +: N]),
        .gg (nxt_gg[j]),
        .gp (nxt_gp[j]),
        .pg (cg[j*N +: N]),
        .pp (cp[j*N +: N])
      );
    end

    // Extend each bit's prefix by the prefix of the level-k group holding it.
    for (genvar i = 0; i < W; i++) begin : g_bit
      assign nxt_bg[i] = bg_r[i] | (bp_r[i] & cg[i / SPAN]);
      assign nxt_bp[i] = bp_r[i] & cp[i / SPAN];
    end
  end

  logic [W-1:0] carry;
  logic         carry_out;

  // Apply the real carry-in to the absolute prefixes of the top level.
  always_comb begin
    carry     = g_lvl[TOP].nxt_bg | (g_lvl[TOP].nxt_bp & {W{g_lvl[TOP].cin_r}});
    carry_out = g_lvl[TOP].nxt_gg[0] | (g_lvl[TOP].nxt_gp[0] & g_lvl[TOP].cin_r);
  end

  // Output stage: result registers hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
    end else if (advance) begin
      out_valid <= g_lvl[TOP].valid_r;
      sum       <= g_lvl[TOP].pbit_r ^ carry;
      c_out     <= carry_out;
    end
  end

`ifdef PIPELINED_CLA_OVERFLOW_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (advance) begin
      overflow <= carry[W-1] ^ carry_out;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter N, default 4, lookahead group size (bits per group, >=2).
REQ-002 Parameter LEVELS, default 2, number of lookahead levels (>=1); datapath width W = N**LEVELS.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  W  operands.
REQ-008 c_in  input  1  carry-in (add) / ignored (sub).
REQ-009 op  input  1  0 = add, 1 = subtract (a - b).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  W  result.
REQ-013 c_out  output  1  carry-out of MSB (sub: 1 = no borrow).
REQ-014 overflow  output  1  signed two's-complement overflow.

Function
REQ-015 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-016 Pipeline depth LAT = LEVELS+1 stages; a transfer in at edge t SHALL present out_valid with its result after edge t+LAT-1 when never stalled (LAT=3 at defaults).
REQ-017 Stage 1 registers operands, effective b (b or ~b) and effective carry-in (c_in for add, 1 for sub), plus per-bit g=a&b', p=a^b'.
REQ-018 Stages 2..LAT each resolve one lookahead level (group generate/propagate up, carries down); final stage registers sum, c_out, overflow.
REQ-019 Advance = out_ready || !out_valid; all stages shift together on advance, hold otherwise; in_ready = advance (combinational from out_ready and out_valid only).
REQ-020 Empty stages (bubbles) carry valid=0 and SHALL not produce output; results SHALL leave in acceptance order, none dropped or duplicated.
REQ-021 Throughput one result per cycle when out_ready held 1.
REQ-022 sum = (a + b_eff + cin_eff) mod 2**W; c_out = bit W of that sum.
REQ-023 overflow = carry into MSB XOR c_out.
REQ-024 Data outputs while out_valid=0 are don't-care but SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 in_valid with in_ready=0 SHALL not be captured; upstream holds.

Reset
REQ-026 rst_n low asynchronously clears all stage valid bits; out_valid=0, sum=0, c_out=0, overflow=0 immediately.
REQ-027 In-flight operations at reset are discarded; first acceptance allowed on first edge after rst_n deasserts (in_ready=1).

Configuration
REQ-028 Macro PIPELINED_CLA_OVERFLOW_EN: defined -> overflow computed per REQ-023 and pipelined with sum; undefined -> overflow port present, tied 0, no overflow logic.

Structure
REQ-029 Package cla_pkg holds op encoding (OP_ADD=0, OP_SUB=1) and a width helper returning N**LEVELS.
REQ-030 One sub-module cla_group_stage: N-bit group generate/propagate and carry expansion for one group at one level, instantiated per group per level.

Verification (N=4, LEVELS=2, W=16, LAT=3)
REQ-031 add a=0x00FF, b=0x0001, c_in=0, out_ready=1 -> third edge: sum=0x0100, c_out=0, overflow=0.
REQ-032 add a=0xFFFF, b=0x0001, c_in=1 -> sum=0x0001, c_out=1; sub a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, overflow=1 (0 if macro undefined).
REQ-033 back-to-back 8 random ops, out_ready=1 -> 8 consecutive out_valid cycles, results match reference model in order.
REQ-034 out_ready=0 for 5 cycles mid-stream -> pipeline fills, in_ready=0, sum held stable; release -> no loss, order kept.
REQ-035 rst_n pulsed low with 2 ops in flight -> out_valid=0 same cycle, neither result ever emitted.
REQ-036 alternating in_valid 1/0 -> bubbles propagate, out_valid pattern equals input pattern delayed LAT-1 edges.
